// File: rtl/ddr3_phy_pkg.sv
// Shared DDR3 PHY definitions: delay-adjust FSM states, sequencing constants
// and the CKE lane reset nibbles.
package ddr3_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_LWAIT,
        ST_MOVE,
        ST_GAP,
        ST_DONE
    } adj_state_t;

    localparam int unsigned LOAD_WAIT_CYC = 2;
    localparam int unsigned MOVE_GAP_CYC  = 1;
    localparam int unsigned WAIT_CNT_W    = 2;

    localparam logic [3:0] CKE_TX_RST = 4'h0;
    localparam logic [3:0] CKE_OE_RST = 4'hF;

endpackage

// File: rtl/ddr3_cke_lane_ctrl_if.sv
// Delay-adjust request/acknowledge bundle between the training engine
// (master) and the CKE lane controller (slave).
interface ddr3_cke_lane_ctrl_if #(
    parameter int unsigned STEP_W = 8
);
    logic              ADJ_REQ;
    logic              ADJ_LOAD;
    logic              ADJ_DIR;
    logic [STEP_W-1:0] ADJ_STEPS;
    logic              ADJ_ACK;
    logic              ADJ_DONE;
    logic              ADJ_BUSY;
    logic              ADJ_OOR;
    logic [STEP_W-1:0] ADJ_MOVED;
    logic [9:0]        ADJ_POS;

    modport master (
        output ADJ_REQ, ADJ_LOAD, ADJ_DIR, ADJ_STEPS,
        input  ADJ_ACK, ADJ_DONE, ADJ_BUSY, ADJ_OOR, ADJ_MOVED, ADJ_POS
    );

    modport slave (
        input  ADJ_REQ, ADJ_LOAD, ADJ_DIR, ADJ_STEPS,
        output ADJ_ACK, ADJ_DONE, ADJ_BUSY, ADJ_OOR, ADJ_MOVED, ADJ_POS
    );
endinterface

// File: rtl/ddr3_cke_delay_adj_fsm.sv
// Sequencer for the CKE lane dynamic delay line (load / direction / move).
// DDR3_CKE_ADJ_POS_EN builds the saturating signed position accumulator.
module ddr3_cke_delay_adj_fsm
    import ddr3_phy_pkg::*;
#(
    parameter int unsigned STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adj_req,
    input  logic              adj_load,
    input  logic              adj_dir,
    input  logic [STEP_W-1:0] adj_steps,
    output logic              adj_ack,
    output logic              adj_done,
    output logic              adj_busy,
    output logic              adj_oor,
    output logic [STEP_W-1:0] adj_moved,
    output logic [9:0]        adj_pos,
    output logic              dl_move,
    output logic              dl_dir,
    output logic              dl_load,
    input  logic              dl_oor
);

    adj_state_t            state;
    logic                  load_q;
    logic                  dir_q;
    logic [STEP_W-1:0]     steps_q;
    logic [WAIT_CNT_W-1:0] cnt;

    // Outputs are registered, so each one appears the cycle after its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            load_q    <= 1'b0;
            dir_q     <= 1'b0;
            steps_q   <= '0;
            cnt       <= '0;
            adj_ack   <= 1'b0;
            adj_done  <= 1'b0;
            adj_busy  <= 1'b0;
            adj_oor   <= 1'b0;
            adj_moved <= '0;
            dl_move   <= 1'b0;
            dl_dir    <= 1'b0;
            dl_load   <= 1'b0;
        end else begin
            adj_ack  <= 1'b0;
            adj_done <= 1'b0;
            dl_move  <= 1'b0;
            dl_load  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    adj_busy <= adj_req;
                    if (adj_req) begin
                        adj_ack <= 1'b1;
                        load_q  <= adj_load;
                        dir_q   <= adj_dir;
                        steps_q <= adj_steps;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    dl_dir    <= dir_q;
                    adj_moved <= '0;
                    if (load_q)
                        state <= ST_LOAD;
                    else if (steps_q == '0)
                        state <= ST_DONE;
                    else
                        state <= ST_MOVE;
                end
                ST_LOAD: begin
                    dl_load <= 1'b1;
                    adj_oor <= 1'b0;
                    cnt     <= WAIT_CNT_W'(LOAD_WAIT_CYC - 1);
                    state   <= ST_LWAIT;
                end
                ST_LWAIT: begin
                    if (cnt == '0)
                        state <= ST_DONE;
                    else
                        cnt <= cnt - WAIT_CNT_W'(1);
                end
                ST_MOVE: begin
                    dl_move   <= 1'b1;
                    adj_moved <= adj_moved + STEP_W'(1);
                    cnt       <= WAIT_CNT_W'(MOVE_GAP_CYC - 1);
                    state     <= ST_GAP;
                end
                ST_GAP: begin
                    // Out-of-range wins over step completion.
                    if (cnt != '0)
                        cnt <= cnt - WAIT_CNT_W'(1);
                    else if (dl_oor) begin
                        adj_oor <= 1'b1;
                        state   <= ST_DONE;
                    end else if (adj_moved == steps_q)
                        state <= ST_DONE;
                    else
                        state <= ST_MOVE;
                end
                ST_DONE: begin
                    adj_done <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DDR3_CKE_ADJ_POS_EN
    localparam logic signed [9:0] POS_MAX = 10'sd511;
    localparam logic signed [9:0] POS_MIN = -10'sd512;

    logic signed [9:0] pos_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pos_q <= '0;
        else if (state == ST_LOAD)
            pos_q <= '0;
        else if (state == ST_MOVE) begin
            if (dir_q && pos_q != POS_MAX)
                pos_q <= pos_q + 10'sd1;
            else if (!dir_q && pos_q != POS_MIN)
                pos_q <= pos_q - 10'sd1;
        end
    end

    assign adj_pos = pos_q;
`else
    assign adj_pos = '0;
`endif

endmodule

// File: rtl/ddr3_cke_lane_ctrl.sv
// DDR3 CKE lane fabric driver: TX/OE nibble pipeline plus delay-line adjust.
// Optional position tracking is enabled with DDR3_CKE_ADJ_POS_EN.
module ddr3_cke_lane_ctrl
    import ddr3_phy_pkg::*;
#(
    parameter int unsigned TX_LAT = 1,
    parameter int unsigned STEP_W = 8
) (
    input  logic                 FAB_CLK,
    input  logic                 ARST_N,
    input  logic                 TX_SYNC_RST,
    input  logic [3:0]           CKE_PH,
    input  logic                 CKE_OE,
    output logic [3:0]           TX_DATA_0,
    output logic [3:0]           OE_DATA_0,
    ddr3_cke_lane_ctrl_if.slave  adj,
    output logic                 DELAY_LINE_MOVE_0,
    output logic                 DELAY_LINE_DIRECTION_0,
    output logic                 DELAY_LINE_LOAD_0,
    input  logic                 DELAY_LINE_OUT_OF_RANGE_0
);

    logic [3:0] tx_pipe [TX_LAT];
    logic [3:0] oe_pipe [TX_LAT];

    // Every stage reloads the CKE-low nibbles so reset never leaks stale data.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            for (int unsigned i = 0; i < TX_LAT; i++) begin
                tx_pipe[i] <= CKE_TX_RST;
                oe_pipe[i] <= CKE_OE_RST;
            end
        end else if (TX_SYNC_RST) begin
            for (int unsigned i = 0; i < TX_LAT; i++) begin
                tx_pipe[i] <= CKE_TX_RST;
                oe_pipe[i] <= CKE_OE_RST;
            end
        end else begin
            tx_pipe[0] <= CKE_PH;
            oe_pipe[0] <= {4{CKE_OE}};
            for (int unsigned i = 1; i < TX_LAT; i++) begin
                tx_pipe[i] <= tx_pipe[i-1];
                oe_pipe[i] <= oe_pipe[i-1];
            end
        end
    end

    assign TX_DATA_0 = tx_pipe[TX_LAT-1];
    assign OE_DATA_0 = oe_pipe[TX_LAT-1];

    ddr3_cke_delay_adj_fsm #(
        .STEP_W (STEP_W)
    ) u_adj_fsm (
        .clk       (FAB_CLK),
        .rst_n     (ARST_N),
        .adj_req   (adj.ADJ_REQ),
        .adj_load  (adj.ADJ_LOAD),
        .adj_dir   (adj.ADJ_DIR),
        .adj_steps (adj.ADJ_STEPS),
        .adj_ack   (adj.ADJ_ACK),
        .adj_done  (adj.ADJ_DONE),
        .adj_busy  (adj.ADJ_BUSY),
        .adj_oor   (adj.ADJ_OOR),
        .adj_moved (adj.ADJ_MOVED),
        .adj_pos   (adj.ADJ_POS),
        .dl_move   (DELAY_LINE_MOVE_0),
        .dl_dir    (DELAY_LINE_DIRECTION_0),
        .dl_load   (DELAY_LINE_LOAD_0),
        .dl_oor    (DELAY_LINE_OUT_OF_RANGE_0)
    );

endmodule

// File: tb/tb_ddr3_cke_lane_ctrl.sv
// Bench for ddr3_cke_lane_ctrl: TX/OE pipeline and delay-adjust sequencing
// against a cycle-timeline reference model (honours DDR3_CKE_ADJ_POS_EN).
module tb_ddr3_cke_lane_ctrl;

    localparam int unsigned TX_LAT = 2;
    localparam int unsigned STEP_W = 8;
    localparam int          TX_N   = 48;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       tx_sync_rst;
    logic [3:0] cke_ph;
    logic       cke_oe;
    logic [3:0] tx_data;
    logic [3:0] oe_data;
    logic       dl_move;
    logic       dl_dir;
    logic       dl_load;
    logic       dl_oor;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference-model state carried between operations.
    bit m_dir;
    bit m_oor;
    int m_pos;

    logic [3:0] tin [TX_N];
    bit         toe [TX_N];
    bit         tsr [TX_N];

    ddr3_cke_lane_ctrl_if #(.STEP_W(STEP_W)) adj ();

    ddr3_cke_lane_ctrl #(
        .TX_LAT (TX_LAT),
        .STEP_W (STEP_W)
    ) dut (
        .FAB_CLK                   (clk),
        .ARST_N                    (arst_n),
        .TX_SYNC_RST               (tx_sync_rst),
        .CKE_PH                    (cke_ph),
        .CKE_OE                    (cke_oe),
        .TX_DATA_0                 (tx_data),
        .OE_DATA_0                 (oe_data),
        .adj                       (adj),
        .DELAY_LINE_MOVE_0         (dl_move),
        .DELAY_LINE_DIRECTION_0    (dl_dir),
        .DELAY_LINE_LOAD_0         (dl_load),
        .DELAY_LINE_OUT_OF_RANGE_0 (dl_oor)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] exp_pos();
`ifdef DDR3_CKE_ADJ_POS_EN
        return 10'(m_pos);
`else
        return 10'd0;
`endif
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_tx"},    32'(tx_data), 32'h0);
        check({tag, "_oe"},    32'(oe_data), 32'hF);
        check({tag, "_ack"},   32'(adj.ADJ_ACK), 32'h0);
        check({tag, "_done"},  32'(adj.ADJ_DONE), 32'h0);
        check({tag, "_busy"},  32'(adj.ADJ_BUSY), 32'h0);
        check({tag, "_oor"},   32'(adj.ADJ_OOR), 32'h0);
        check({tag, "_moved"}, 32'(adj.ADJ_MOVED), 32'h0);
        check({tag, "_pos"},   32'(adj.ADJ_POS), 32'h0);
        check({tag, "_move"},  32'(dl_move), 32'h0);
        check({tag, "_dir"},   32'(dl_dir), 32'h0);
        check({tag, "_load"},  32'(dl_load), 32'h0);
    endtask

    task automatic issue(input bit ld, input bit dr, input int st);
        adj.ADJ_REQ   = 1'b1;
        adj.ADJ_LOAD  = ld;
        adj.ADJ_DIR   = dr;
        adj.ADJ_STEPS = STEP_W'(st);
    endtask

    // Follows one accepted operation from cycle 0 (ACK) to its DONE cycle.
    // k != 0 raises out-of-range in the cycle of the k-th MOVE pulse.
    // hold keeps ADJ_REQ high with the next request's fields on the bus.
    task automatic track(input bit ld, input bit dr, input int st, input int k,
                         input bit hold, input bit nld, input bit ndr, input int nst);
        int nm;
        int done_c;
        bit exp_mv;
        nm     = ld ? 0 : ((k != 0) ? k : st);
        done_c = ld ? 5 : 2 * nm + 2;
        if (ld) begin
            m_oor = 1'b0;
            m_pos = 0;
        end else begin
            if (k != 0) m_oor = 1'b1;
            for (int i = 0; i < nm; i++)
                m_pos = dr ? ((m_pos < 511) ? m_pos + 1 : 511)
                           : ((m_pos > -512) ? m_pos - 1 : -512);
        end
        for (int c = 0; c <= done_c; c++) begin
            @(negedge clk);
            exp_mv = !ld && c >= 2 && c <= 2 * nm && (c % 2 == 0);
            check("ack",  32'(adj.ADJ_ACK),  32'(c == 0));
            check("move", 32'(dl_move),      32'(exp_mv));
            check("load", 32'(dl_load),      32'(ld && c == 2));
            check("done", 32'(adj.ADJ_DONE), 32'(c == done_c));
            check("busy", 32'(adj.ADJ_BUSY), 32'h1);
            check("dir",  32'(dl_dir),       32'((c >= 1) ? dr : m_dir));
            if (c == done_c) begin
                check("moved", 32'(adj.ADJ_MOVED), 32'(nm));
                check("oor",   32'(adj.ADJ_OOR),   32'(m_oor));
                check("pos",   32'(adj.ADJ_POS),   32'(exp_pos()));
            end
            if (c == 0) begin
                if (hold) begin
                    adj.ADJ_LOAD  = nld;
                    adj.ADJ_DIR   = ndr;
                    adj.ADJ_STEPS = STEP_W'(nst);
                end else begin
                    adj.ADJ_REQ = 1'b0;
                end
            end
            if (!ld && k != 0 && c == 2 * k) dl_oor = 1'b1;
            if (c == done_c) dl_oor = 1'b0;
        end
        m_dir = dr;
        if (!hold) begin
            @(negedge clk);
            check("idle_ack",  32'(adj.ADJ_ACK),  32'h0);
            check("idle_busy", 32'(adj.ADJ_BUSY), 32'h0);
            check("idle_done", 32'(adj.ADJ_DONE), 32'h0);
            check("idle_move", 32'(dl_move),      32'h0);
        end
    endtask

    initial begin
        int lo;
        bit rs;
        bit ld;
        bit dr;
        int st;
        int k;

        arst_n        = 1'b0;
        tx_sync_rst   = 1'b0;
        cke_ph        = 4'hF;
        cke_oe        = 1'b1;
        dl_oor        = 1'b0;
        adj.ADJ_REQ   = 1'b0;
        adj.ADJ_LOAD  = 1'b0;
        adj.ADJ_DIR   = 1'b0;
        adj.ADJ_STEPS = '0;
        m_dir = 1'b0;
        m_oor = 1'b0;
        m_pos = 0;

        repeat (3) begin
            @(negedge clk);
            check_reset("rst");
        end
        arst_n = 1'b1;

        // TX/OE path: edge e captures tin[e]; output after edge e is tin[e-TX_LAT+1]
        // unless a sync clear hit any edge in that window.
        for (int e = 0; e < TX_N; e++) begin
            if (e < 6) begin
                tin[e] = 4'hF;
                toe[e] = 1'b1;
                tsr[e] = 1'b0;
            end else begin
                tin[e] = 4'($urandom);
                toe[e] = 1'($urandom);
                tsr[e] = ($urandom_range(0, 7) == 0);
            end
            cke_ph      = tin[e];
            cke_oe      = toe[e];
            tx_sync_rst = tsr[e];
            @(negedge clk);
            lo = e - int'(TX_LAT) + 1;
            rs = (lo < 0);
            for (int j = (lo < 0) ? 0 : lo; j <= e; j++)
                if (tsr[j]) rs = 1'b1;
            check("tx_data", 32'(tx_data), rs ? 32'h0 : 32'(tin[lo]));
            check("oe_data", 32'(oe_data), rs ? 32'hF : 32'({4{toe[lo]}}));
        end
        tx_sync_rst = 1'b0;
        @(negedge clk);

        issue(1'b0, 1'b1, 3);
        track(1'b0, 1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 0);

        issue(1'b0, 1'b1, 10);
        track(1'b0, 1'b1, 10, 4, 1'b0, 1'b0, 1'b0, 0);

        issue(1'b1, 1'b0, 0);
        track(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);

        // Back-to-back with ADJ_REQ held high: second ACK one cycle after DONE.
        issue(1'b0, 1'b0, 2);
        track(1'b0, 1'b0, 2, 0, 1'b1, 1'b0, 1'b1, 0);
        track(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0);

        // Asynchronous reset on the cycle of the 2nd MOVE pulse.
        issue(1'b0, 1'b1, 5);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c == 0) adj.ADJ_REQ = 1'b0;
        end
        check("rst_mid_move", 32'(dl_move), 32'h1);
        arst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_no_done", 32'(adj.ADJ_DONE), 32'h0);
        end
        arst_n = 1'b1;
        m_dir = 1'b0;
        m_oor = 1'b0;
        m_pos = 0;
        @(negedge clk);
        issue(1'b0, 1'b1, 5);
        track(1'b0, 1'b1, 5, 0, 1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            ld = ($urandom_range(0, 3) == 0);
            dr = 1'($urandom);
            st = int'($urandom_range(0, 7));
            k  = (!ld && st > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, st)) : 0;
            issue(ld, dr, st);
            track(ld, dr, st, k, 1'b0, 1'b0, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_cke_lane_ctrl.md
# ddr3_cke_lane_ctrl

Fabric-side driver for the DDR3 CKE output lane. It converts the per-phase CKE and output-enable requests from the DDR3 controller into the 4-bit TX/OE nibbles consumed by the CKE I/O delay block each FAB_CLK cycle. It also sequences the lane's dynamic output delay line (load, direction, move) under a request/acknowledge handshake from the training engine. It sits directly upstream of the CKE IOD in the DDR3 PHY block, in the FAB_CLK domain.

## Interface
Parameters:
- TX_LAT, 1 — number of register stages on the TX/OE path (legal values 1..4).
- STEP_W, 8 — width of the step count in an adjust request.

Ports:
- FAB_CLK  in  1  — fabric clock, the 1/4 rate of HS_IO_CLK; the only clock.
- ARST_N  in  1  — asynchronous, active-low reset. It clears all state.
- TX_SYNC_RST  in  1  — synchronous, active-high clear of the TX/OE path only.
- CKE_PH  in  4  — per-phase CKE value; bit 0 is the earliest transmitted phase.
- CKE_OE  in  1  — pad output-enable request.
- TX_DATA_0  out  4  — CKE nibble to the IOD.
- OE_DATA_0  out  4  — OE nibble to the IOD.
- ADJ_REQ  in  1  — delay adjust request (level).
- ADJ_LOAD  in  1  — 1 = reload the delay line default; 0 = move by steps.
- ADJ_DIR  in  1  — move direction, passed through unchanged to the IOD.
- ADJ_STEPS  in  STEP_W  — number of MOVE pulses requested.
- ADJ_ACK  out  1  — one-cycle pulse when a request is accepted.
- ADJ_DONE  out  1  — one-cycle pulse when an operation completes.
- ADJ_BUSY  out  1  — high from acceptance through the ADJ_DONE cycle.
- ADJ_OOR  out  1  — sticky out-of-range flag.
- ADJ_MOVED  out  STEP_W  — count of MOVE pulses issued by the last operation.
- ADJ_POS  out  10  — signed net position since the last load (see Configuration).
- DELAY_LINE_MOVE_0  out  1  — delay line move pulse to the IOD.
- DELAY_LINE_DIRECTION_0  out  1  — delay line direction to the IOD.
- DELAY_LINE_LOAD_0  out  1  — delay line load pulse to the IOD.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  — out-of-range status from the IOD, synchronous to FAB_CLK.

## Operation
TX/OE path:
- TX_DATA_0 is CKE_PH delayed by TX_LAT registers.
- OE_DATA_0 is {4{CKE_OE}} delayed by TX_LAT registers.
- On reset or TX_SYNC_RST, every stage loads TX=4'b0000 and OE=4'b1111, so CKE is driven low, as JEDEC requires during reset.

Adjust FSM states: IDLE, SETUP, LOAD, LWAIT, MOVE, GAP, DONE.
- IDLE: when ADJ_REQ=1, capture ADJ_LOAD, ADJ_DIR and ADJ_STEPS, pulse ADJ_ACK, and go to SETUP. ADJ_REQ is ignored in every other state.
- SETUP: drive DELAY_LINE_DIRECTION_0 to the captured direction and clear ADJ_MOVED.
  - If ADJ_LOAD=1, go to LOAD.
  - Else if steps=0, go to DONE.
  - Else go to MOVE.
- LOAD: DELAY_LINE_LOAD_0=1 for one cycle. Clear ADJ_OOR and ADJ_POS. Go to LWAIT.
- LWAIT: wait 2 cycles, then go to DONE.
- MOVE: DELAY_LINE_MOVE_0=1 for one cycle, increment ADJ_MOVED, and go to GAP.
- GAP: one cycle. The registered OUT_OF_RANGE status is checked here.
  - If OUT_OF_RANGE=1, set ADJ_OOR and go to DONE.
  - Else if ADJ_MOVED==steps, go to DONE.
  - Else go to MOVE.
- DONE: pulse ADJ_DONE and return to IDLE. A request is accepted no earlier than the cycle after DONE.

Signal rules:
- DELAY_LINE_DIRECTION_0 holds its value between operations. It never changes in the same cycle as a MOVE pulse.
- ADJ_OOR is cleared only by ARST_N or by a load operation.

## Timing
- Reset values: TX_DATA_0=0, OE_DATA_0=4'hF. All other outputs are 0, and the FSM is in IDLE.
- TX path latency is exactly TX_LAT FAB_CLK cycles.
- Move sequence, with cycle 0 = the cycle after the accepting edge:
  - cycle 0: ADJ_ACK.
  - cycle 1: SETUP; DIRECTION is valid.
  - MOVE pulses on cycles 2, 4, …, 2N.
  - ADJ_DONE on cycle 2N+2.
- Zero-step move: ADJ_DONE on cycle 2.
- Load sequence: LOAD pulse on cycle 2, ADJ_DONE on cycle 5.
- Out-of-range seen in the GAP after pulse k: no further MOVE, and ADJ_DONE on cycle 2k+2.
- ARST_N during an operation: immediate return to IDLE with no ADJ_DONE, and all pulse outputs drop asynchronously.
- TX_SYNC_RST never affects the FSM.

## Configuration
- DDR3_CKE_ADJ_POS_EN defined: ADJ_POS is a signed 10-bit register.
  - It adds +1 for each MOVE with direction 1 and −1 for each MOVE with direction 0.
  - It saturates at +511/−512.
  - It clears on load.
- DDR3_CKE_ADJ_POS_EN undefined: ADJ_POS is tied to 0 and the accumulator is not built.

## Structure
- The shared package ddr3_phy_pkg holds:
  - the FSM state enum;
  - LOAD_WAIT_CYC=2 and MOVE_GAP_CYC=1;
  - the CKE reset nibble constants (TX 4'h0, OE 4'hF).
- The adjust FSM is a sub-module, ddr3_cke_delay_adj_fsm. The top level keeps the TX/OE pipeline.

## Test plan
- Hold reset, then release with CKE_PH=4'hF and CKE_OE=1. Outputs are 0/F during reset; TX_DATA_0 becomes 4'hF exactly TX_LAT cycles after release.
- Move request with STEPS=3 and DIR=1. Expect ACK on cycle 0, MOVE pulses on cycles 2, 4 and 6, DONE on cycle 8, ADJ_MOVED=3, and ADJ_POS=+3 when the macro is defined.
- Move request with STEPS=10, with OUT_OF_RANGE forced high after the 4th MOVE. Expect exactly 4 MOVE pulses, DONE on cycle 10, ADJ_OOR=1, and ADJ_MOVED=4.
- Load request after an out-of-range event. Expect LOAD on cycle 2, DONE on cycle 5, and ADJ_OOR=0 and ADJ_POS=0 afterwards.
- ADJ_REQ held high continuously. The next ACK comes exactly one cycle after DONE, and no request is accepted while BUSY=1.
- ARST_N asserted on the cycle of the 2nd MOVE in a STEPS=5 operation. All outputs go to their reset values, with no DONE. A new request after reset runs the full sequence normally.
